nibble_serial_addsub: RTL and testbench

- Multi-cycle WIDTH-bit adder/subtractor built around one shared 4-bit ripple-carry slice.
- Processes one nibble per clock, LSB first, and holds the carry in a flop between nibbles.
- Sits between the control path and the 4-bit adder datapath; trades latency for area.
- Uses a start/busy/done handshake toward the requester.

---
 rtl/addsub_pkg.sv | 17 +
 rtl/nibble_adder.sv | 26 ++
 rtl/nibble_serial_addsub.sv | 120 ++++++++++++
 tb/tb_nibble_serial_addsub.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// Shared types and sizing for the nibble-serial add/subtract datapath.
// Holds the FSM state encoding, the slice width and the nibble-step helper.
package addsub_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int nib_count(input int width);
    return width / NIB_W;
  endfunction

endpackage

// File: rtl/nibble_adder.sv
// 4-bit ripple-carry slice shared by every nibble step of the serial adder.
// Purely combinational, zero latency, no flow control.
module nibble_adder
  import addsub_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             cin,
  output logic [NIB_W-1:0] sum,
  output logic             cout
);

  logic [NIB_W:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int i = 0; i < NIB_W; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    cout = c[NIB_W];
  end

endmodule

// File: rtl/nibble_serial_addsub.sv
// WIDTH-bit add/subtract computed one nibble per clock through a single shared slice.
// Result/flags valid with done, WIDTH/4 cycles after an accepted start; start is ignored while busy.
module nibble_serial_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);

  localparam int NNIB = nib_count(WIDTH);
  localparam int CW   = (NNIB > 1) ? $clog2(NNIB) : 1;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_q, b_q;
  logic             op_sub_q;
  logic [CW-1:0]    cnt;
  logic             carry;

  logic             accept;
  logic             last;
  logic [NIB_W-1:0] a_nib, b_nib, sum_nib;
  logic             slice_cout;
  logic [WIDTH-1:0] res_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
          accept    = 1'b1;
        end
      end
      RUN: begin
        if (last) state_nxt = DONE;
      end
      DONE: begin
        // Back-to-back starts skip IDLE entirely.
        if (start) begin
          state_nxt = RUN;
          accept    = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);
  assign last = (cnt == CW'(NNIB - 1));

  assign a_nib = a_q[NIB_W*cnt +: NIB_W];
  assign b_nib = b_q[NIB_W*cnt +: NIB_W] ^ {NIB_W{op_sub_q}};

  nibble_adder u_slice (
    .a    (a_nib),
    .b    (b_nib),
    .cin  (carry),
    .sum  (sum_nib),
    .cout (slice_cout)
  );

  // Full result as it will look after this edge, so flags see the final nibble.
  always_comb begin
    res_nxt = result;
    res_nxt[NIB_W*cnt +: NIB_W] = sum_nib;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      op_sub_q <= 1'b0;
      cnt      <= '0;
      carry    <= 1'b0;
      result   <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
    end else if (accept) begin
      a_q      <= a;
      b_q      <= b;
      op_sub_q <= op_sub;
      cnt      <= '0;
      // Subtraction is a + ~b + 1; the +1 enters as the first carry-in.
      carry    <= op_sub;
    end else if (state == RUN) begin
      result <= res_nxt;
      carry  <= slice_cout;
      cnt    <= cnt + 1'b1;
      if (last) begin
        cout     <= slice_cout;
        overflow <= (a_q[WIDTH-1] == (b_q[WIDTH-1] ^ op_sub_q)) &&
                    (res_nxt[WIDTH-1] != a_q[WIDTH-1]);
        zero     <= ~|res_nxt;
      end
    end
  end

endmodule

// File: tb/tb_nibble_serial_addsub.sv
// Directed bench for nibble_serial_addsub with a per-cycle arithmetic reference model.
module tb_nibble_serial_addsub;

  localparam int WIDTH = 16;
  localparam int NNIB  = WIDTH / 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              op_sub = 1'b0;
  logic [WIDTH-1:0]  a = '0;
  logic [WIDTH-1:0]  b = '0;
  logic              busy, done, cout, overflow, zero;
  logic [WIDTH-1:0]  result;

  int errors = 0;
  int checks = 0;

  nibble_serial_addsub #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op_sub   (op_sub),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .cout     (cout),
    .overflow (overflow),
    .zero     (zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference arithmetic on whole words.
  function automatic logic [WIDTH-1:0] m_result(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic s);
    return s ? (x - y) : (x + y);
  endfunction

  function automatic logic m_carry(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic s);
    if (s) return (x >= y);
    return ((int'(x) + int'(y)) > 65535);
  endfunction

  function automatic logic m_ovf(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic s);
    int sx, sy, r;
    sx = int'($signed(x));
    sy = int'($signed(y));
    r  = s ? (sx - sy) : (sx + sy);
    return (r > 32767) || (r < -32768);
  endfunction

  // Model: a job occupies NNIB busy cycles, then one done cycle publishing its answer.
  int               m_left;
  logic             m_done;
  logic [WIDTH-1:0] m_res, p_res;
  logic             m_cout, m_ovf_q, m_zero, p_cout, p_ovf, p_zero;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left  <= 0;
      m_done  <= 1'b0;
      m_res   <= '0;
      m_cout  <= 1'b0;
      m_ovf_q <= 1'b0;
      m_zero  <= 1'b0;
      p_res   <= '0;
      p_cout  <= 1'b0;
      p_ovf   <= 1'b0;
      p_zero  <= 1'b0;
    end else begin
      m_done <= (m_left == 1);
      if (m_left == 1) begin
        m_res   <= p_res;
        m_cout  <= p_cout;
        m_ovf_q <= p_ovf;
        m_zero  <= p_zero;
      end
      if (m_left == 0 && start) begin
        m_left <= NNIB;
        p_res  <= m_result(a, b, op_sub);
        p_cout <= m_carry(a, b, op_sub);
        p_ovf  <= m_ovf(a, b, op_sub);
        p_zero <= (m_result(a, b, op_sub) == '0);
      end else if (m_left > 0) begin
        m_left <= m_left - 1;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("busy", 32'(busy), 32'(m_left != 0));
      chk("done", 32'(done), 32'(m_done));
      if (m_left == 0) begin
        chk("result", 32'(result), 32'(m_res));
        chk("cout", 32'(cout), 32'(m_cout));
        chk("overflow", 32'(overflow), 32'(m_ovf_q));
        chk("zero", 32'(zero), 32'(m_zero));
      end
    end
  end

  task automatic idle(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic do_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tbv, input logic ts,
                       input logic [WIDTH-1:0] er, input logic ec, input logic eo, input logic ez,
                       input string nm);
    int n;
    a = ta;
    b = tbv;
    op_sub = ts;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(n);
    chk({nm, "_latency"}, 32'(n), 32'(NNIB));
    chk({nm, "_result"}, 32'(result), 32'(er));
    chk({nm, "_cout"}, 32'(cout), 32'(ec));
    chk({nm, "_ovf"}, 32'(overflow), 32'(eo));
    chk({nm, "_zero"}, 32'(zero), 32'(ez));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    #3;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_flags", 32'({cout, overflow, zero}), 32'd0);
    idle(2);
    rst_n = 1'b1;
    idle(2);

    do_op(16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b0, "add_plain");
    idle(2);
    do_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, "add_wrap");
    do_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, "add_ovf");
    idle(1);
    do_op(16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0, "sub_borrow");
    idle(1);
    do_op(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0, "sub_ovf");
    idle(2);

    // A second start during RUN must neither alter nor queue anything.
    a = 16'h1234; b = 16'h0FFF; op_sub = 1'b0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    a = 16'h1111; b = 16'h1111; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    wait_done(n);
    chk("ign_done_seen", 32'(done), 32'd1);
    chk("ign_result", 32'(result), 32'h2233);
    for (int i = 0; i < 5; i++) begin
      idle(1);
      chk("ign_no_second_done", 32'(done), 32'd0);
    end

    do_op(16'h1111, 16'h1111, 1'b0, 16'h2222, 1'b0, 1'b0, 1'b0, "idle_start");
    // Start during the done cycle; the old result must hold through that cycle.
    a = 16'h0001; b = 16'h0002; op_sub = 1'b0; start = 1'b1;
    #2;
    chk("b2b_prev_done", 32'(done), 32'd1);
    chk("b2b_prev_result", 32'(result), 32'h2222);
    @(posedge clk); #1; start = 1'b0;
    chk("b2b_busy", 32'(busy), 32'd1);
    wait_done(n);
    chk("b2b_latency", 32'(n), 32'(NNIB));
    chk("b2b_result", 32'(result), 32'h0003);
    idle(2);

    // Reset in the middle of a run clears everything immediately.
    a = 16'h1234; b = 16'h1111; op_sub = 1'b0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    idle(2);
    chk("mid_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_result", 32'(result), 32'd0);
    chk("mid_rst_flags", 32'({cout, overflow, zero}), 32'd0);
    idle(2);
    rst_n = 1'b1;
    idle(1);
    do_op(16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0, "after_rst");
    idle(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
